// File: rtl/ysyx_23060077_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of a single AXI4 AR/R master.
// Grants one whole burst at a time: IDLE picks a client, AR launches it, R steers beats back.
module ysyx_23060077_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              c0_valid_i,
  input  logic [ADDR_W-1:0] c0_addr_i,
  input  logic [LEN_W-1:0]  c0_len_i,
  output logic              c0_ready_o,
  output logic [DATA_W-1:0] c0_data_o,
  output logic              c0_last_o,
  output logic              c0_err_o,
  input  logic              c1_valid_i,
  input  logic [ADDR_W-1:0] c1_addr_i,
  input  logic [LEN_W-1:0]  c1_len_i,
  output logic              c1_ready_o,
  output logic [DATA_W-1:0] c1_data_o,
  output logic              c1_last_o,
  output logic              c1_err_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [LEN_W-1:0]  arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  output logic              proto_err_o
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t            state, state_nxt;
  logic              grant, grant_nxt, last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, cnt;
  logic              proto_err;
  logic              any_req, beat;

  assign any_req = c0_valid_i | c1_valid_i;
  assign beat    = (state == R) && rvalid_i;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: if (any_req) begin
        // on a tie the client that did not own the previous burst wins
        grant_nxt = (c0_valid_i && c1_valid_i) ? ~last_grant : c1_valid_i;
        state_nxt = AR;
      end
      AR:      if (arready_i) state_nxt = R;
      R:       if (rvalid_i && rlast_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == IDLE && any_req) begin
        addr_q <= grant_nxt ? c1_addr_i : c0_addr_i;
        len_q  <= grant_nxt ? c1_len_i  : c0_len_i;
      end
      if (state == AR && arready_i) cnt <= '0;
      if (beat) begin
        cnt <= cnt + LEN_W'(1);
        // rlast must land exactly on beat arlen; the burst still ends only on rlast
        if (rlast_i != (cnt == len_q)) proto_err <= 1'b1;
        if (rlast_i) last_grant <= grant;
      end
    end
  end

  assign arvalid_o   = (state == AR);
  assign araddr_o    = addr_q;
  assign arlen_o     = len_q;
  assign arsize_o    = 3'b010;
  assign arburst_o   = 2'b01;
  assign rready_o    = (state == R);
  assign proto_err_o = proto_err;

  assign c0_ready_o = beat && !grant;
  assign c0_data_o  = c0_ready_o ? rdata_i : '0;
  assign c0_last_o  = c0_ready_o && rlast_i;
  assign c0_err_o   = c0_ready_o && (rresp_i != 2'b00);
  assign c1_ready_o = beat && grant;
  assign c1_data_o  = c1_ready_o ? rdata_i : '0;
  assign c1_last_o  = c1_ready_o && rlast_i;
  assign c1_err_o   = c1_ready_o && (rresp_i != 2'b00);

endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Random client/slave traffic scored against a round-robin reference model, plus directed
// tie, latency, SLVERR and mid-burst reset scenarios.
module tb_ysyx_23060077_rd_arbiter;
  logic        clock, reset_n;
  logic        c0_valid_i, c1_valid_i;
  logic [31:0] c0_addr_i, c1_addr_i;
  logic [7:0]  c0_len_i, c1_len_i;
  logic        c0_ready_o, c0_last_o, c0_err_o, c1_ready_o, c1_last_o, c1_err_o;
  logic [31:0] c0_data_o, c1_data_o;
  logic        arvalid_o, arready_i, rvalid_i, rready_o, rlast_i, proto_err_o;
  logic [31:0] araddr_o, rdata_i;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o, rresp_i;

  ysyx_23060077_rd_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .c0_valid_i(c0_valid_i), .c0_addr_i(c0_addr_i), .c0_len_i(c0_len_i),
    .c0_ready_o(c0_ready_o), .c0_data_o(c0_data_o), .c0_last_o(c0_last_o), .c0_err_o(c0_err_o),
    .c1_valid_i(c1_valid_i), .c1_addr_i(c1_addr_i), .c1_len_i(c1_len_i),
    .c1_ready_o(c1_ready_o), .c1_data_o(c1_data_o), .c1_last_o(c1_last_o), .c1_err_o(c1_err_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .proto_err_o(proto_err_o));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { bit cl; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { bit cl; logic [31:0] data; bit err; bit last; } beat_t;

  ar_t   ar_q[$];
  ar_t   burst_q[$];
  beat_t beat_q[$];
  bit    en;
  int    total, bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  // Reference model + monitor: who should win, what AR should appear, which beats land where.
  initial begin : monitor
    bit mbusy, mlast, exp_perr, perr_chk, cl;
    int nbeats;
    ar_t e, cur;
    beat_t b;
    mbusy = 0; mlast = 0; exp_perr = 0; perr_chk = 0; nbeats = 0;
    forever begin
      @(negedge clock);
      if (!en) continue;
      if (perr_chk) begin
        chk("proto_err", proto_err_o, exp_perr);
        perr_chk = 0;
      end
      if (!mbusy && (c0_valid_i || c1_valid_i)) begin
        cl = (c0_valid_i && c1_valid_i) ? !mlast : c1_valid_i;
        e.cl = cl;
        e.addr = cl ? c1_addr_i : c0_addr_i;
        e.len  = cl ? c1_len_i : c0_len_i;
        ar_q.push_back(e);
        mbusy = 1;
      end
      if (arvalid_o && arready_i) begin
        if (ar_q.size() == 0) fail("ar_unexpected");
        else begin
          cur = ar_q.pop_front();
          chk("araddr", araddr_o, cur.addr);
          chk("arlen", arlen_o, cur.len);
          chk("arsize", arsize_o, 3'b010);
          chk("arburst", arburst_o, 2'b01);
          burst_q.push_back(cur);
          nbeats = 0;
        end
      end
      if (rvalid_i && rready_o) begin
        if (beat_q.size() == 0) fail("beat_unexpected");
        else begin
          b = beat_q.pop_front();
          chk("c0_ready", c0_ready_o, !b.cl);
          chk("c1_ready", c1_ready_o, b.cl);
          chk("beat_data", b.cl ? c1_data_o : c0_data_o, b.data);
          chk("idle_data", b.cl ? c0_data_o : c1_data_o, 0);
          chk("beat_err", b.cl ? c1_err_o : c0_err_o, b.err);
          chk("beat_last", b.cl ? c1_last_o : c0_last_o, b.last);
          nbeats++;
          if (b.last) begin
            if (nbeats != int'(cur.len) + 1) exp_perr = 1;
            perr_chk = 1;
            mlast = cur.cl;
            mbusy = 0;
          end
        end
      end else if (c0_ready_o || c1_ready_o) fail("spurious_ready");
    end
  end

  task automatic serve(input bit cl, input logic [31:0] ea, input logic [7:0] el,
                       input int ard, input int errb);
    int n;
    logic [31:0] d;
    n = 0;
    while (!arvalid_o && n < 20) begin @(negedge clock); n++; end
    chk("ar_latency", n, 1);
    if (!arvalid_o) begin fail("ar_timeout"); return; end
    if (cl) begin c1_addr_i = ~ea; c1_len_i = ~el; end
    else begin c0_addr_i = ~ea; c0_len_i = ~el; end
    repeat (ard) begin @(negedge clock); chk("ar_hold", arvalid_o, 1); end
    arready_i = 1;
    chk("d_araddr", araddr_o, ea);
    chk("d_arlen", arlen_o, el);
    @(negedge clock);
    arready_i = 0;
    for (int b = 0; b <= int'(el); b++) begin
      d = $urandom;
      rvalid_i = 1; rdata_i = d; rlast_i = (b == int'(el));
      rresp_i = (b == errb) ? 2'b10 : 2'b00;
      #2;
      chk("d_c0_ready", c0_ready_o, !cl);
      chk("d_c1_ready", c1_ready_o, cl);
      chk("d_data", cl ? c1_data_o : c0_data_o, d);
      chk("d_err", cl ? c1_err_o : c0_err_o, b == errb);
      chk("d_last", cl ? c1_last_o : c0_last_o, b == int'(el));
      @(negedge clock);
    end
    rvalid_i = 0; rlast_i = 0; rresp_i = 0;
    if (cl) c1_valid_i = 0; else c0_valid_i = 0;
  endtask

  initial begin : driver
    bit pend[2], v[2], stop, inb, pres, rhs, lst[2], rdy[2];
    logic [31:0] a[2];
    logic [7:0] ln[2];
    int wt[2], idx, nb, k, cyc;
    ar_t curb;
    beat_t eb;
    total = 0; bad = 0; en = 0; stop = 0; inb = 0; pres = 0; idx = 0; nb = 0;
    for (int i = 0; i < 2; i++) begin pend[i] = 0; v[i] = 0; a[i] = 0; ln[i] = 0; wt[i] = 0; end
    c0_valid_i = 0; c0_addr_i = 0; c0_len_i = 0;
    c1_valid_i = 0; c1_addr_i = 0; c1_len_i = 0;
    arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0; rlast_i = 0;
    reset_n = 1;
    #2 reset_n = 0;
    #10;
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_araddr", araddr_o, 0);
    chk("rst_arlen", arlen_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_c0", {c0_ready_o, c0_last_o, c0_err_o, c0_data_o}, 0);
    chk("rst_c1", {c1_ready_o, c1_last_o, c1_err_o, c1_data_o}, 0);
    chk("rst_perr", proto_err_o, 0);
    @(negedge clock);
    reset_n = 1;
    en = 1;

    for (cyc = 0; ; cyc++) begin
      @(negedge clock);
      rhs = rvalid_i && rready_o;
      lst[0] = c0_ready_o && c0_last_o; lst[1] = c1_ready_o && c1_last_o;
      rdy[0] = c0_ready_o; rdy[1] = c1_ready_o;
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          if (lst[i]) begin
            pend[i] = 0; v[i] = 0; wt[i] = (i == 1) ? $urandom_range(0, 1) : $urandom_range(0, 3);
          end else begin
            if (rdy[i] && v[i] && $urandom_range(0, 7) == 0) v[i] = 0;
            if (v[i] && $urandom_range(0, 7) == 0) begin a[i] = $urandom; ln[i] = 8'($urandom_range(0, 5)); end
          end
        end else if (!stop) begin
          if (wt[i] > 0) wt[i]--;
          else begin pend[i] = 1; v[i] = 1; a[i] = $urandom; ln[i] = 8'($urandom_range(0, 5)); end
        end
      end
      c0_valid_i = v[0]; c0_addr_i = a[0]; c0_len_i = ln[0];
      c1_valid_i = v[1]; c1_addr_i = a[1]; c1_len_i = ln[1];
      arready_i = $urandom_range(0, 1) == 1;
      if (pres && rhs) begin
        pres = 0; idx++;
        if (idx == nb) inb = 0;
      end
      if (!inb && burst_q.size() != 0) begin
        curb = burst_q.pop_front();
        inb = 1; idx = 0; nb = int'(curb.len) + 1;
        k = $urandom_range(0, 5);
        if (k == 0 && curb.len > 0) nb = int'(curb.len);
        else if (k == 1) nb = int'(curb.len) + 2;
      end
      if (inb && !pres && $urandom_range(0, 3) != 0) begin
        pres = 1;
        rvalid_i = 1; rdata_i = $urandom;
        rresp_i = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
        rlast_i = (idx == nb - 1);
        eb.cl = curb.cl; eb.data = rdata_i; eb.err = rresp_i != 0; eb.last = rlast_i;
        beat_q.push_back(eb);
      end else if (!pres) begin
        rvalid_i = 0; rlast_i = 0; rresp_i = 0;
      end
      if (cyc >= 3000) stop = 1;
      if (stop && !pend[0] && !pend[1] && !inb && burst_q.size() == 0 && ar_q.size() == 0 &&
          beat_q.size() == 0 && !arvalid_o && !rready_o) break;
      if (cyc >= 4000) begin fail("drain_timeout"); break; end
    end
    arready_i = 0;
    repeat (3) @(negedge clock);
    en = 0;

    // reset in the middle of a burst
    c0_valid_i = 1; c0_addr_i = 32'h4000_0000; c0_len_i = 8'd3;
    k = 0;
    while (!arvalid_o && k < 20) begin @(negedge clock); k++; end
    chk("mr_arvalid", arvalid_o, 1);
    arready_i = 1;
    @(negedge clock);
    arready_i = 0; rvalid_i = 1; rdata_i = 32'hDEAD_BEEF; rlast_i = 0;
    #2;
    chk("mr_c0_ready", c0_ready_o, 1);
    reset_n = 0;
    #1;
    chk("mr_arvalid0", arvalid_o, 0);
    chk("mr_rready0", rready_o, 0);
    chk("mr_ar0", {araddr_o, arlen_o}, 0);
    chk("mr_c00", {c0_ready_o, c0_last_o, c0_err_o, c0_data_o}, 0);
    chk("mr_perr0", proto_err_o, 0);
    rvalid_i = 0; c0_valid_i = 0;
    @(negedge clock);
    reset_n = 1;

    // tie from reset -> c1, then c0, then tie again -> c1
    c0_valid_i = 1; c0_addr_i = 32'h1000_0000; c0_len_i = 8'd1;
    c1_valid_i = 1; c1_addr_i = 32'h2000_0040; c1_len_i = 8'd1;
    serve(1'b1, 32'h2000_0040, 8'd1, 0, -1);
    serve(1'b0, 32'h1000_0000, 8'd1, 0, -1);
    c0_valid_i = 1; c0_addr_i = 32'h1000_0100; c0_len_i = 8'd2;
    c1_valid_i = 1; c1_addr_i = 32'h2000_0080; c1_len_i = 8'd3;
    serve(1'b1, 32'h2000_0080, 8'd3, 1, 1);
    serve(1'b0, 32'h1000_0100, 8'd2, 0, -1);
    c0_valid_i = 1; c0_addr_i = 32'h3000_0010; c0_len_i = 8'd3;
    serve(1'b0, 32'h3000_0010, 8'd3, 2, -1);
    @(negedge clock);
    chk("d_perr", proto_err_o, 0);
    chk("d_idle", {arvalid_o, rready_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
